// File: rtl/spi_piso_shifter.sv
// SPI master transmit serialiser: parallel word in, one bit per shift_en strobe out on mosi.
// A one-entry holding buffer lets the next word be queued while the current one shifts,
// so consecutive words leave back-to-back with no gap bit.
module spi_piso_shifter #(
  parameter int DATA_W     = 8,
  parameter bit LSB_FIRST  = 1'b0,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_W-1:0]         data_in,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic                      shift_en,
  input  logic                      abort,
  output logic                      mosi,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(DATA_W)-1:0] bit_idx
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   r_hold_data;
  logic                r_hold_valid;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_done;

  logic                w_last;
  logic                w_accept;
  logic                w_take;
  logic                w_advance;
  logic [DATA_W-1:0]   w_shifted;

  // State register; reset drops straight back to idle without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake decode; abort overrides every other transition.
  always_comb begin
    w_state_next = r_state;
    w_last       = (r_cnt == LAST_IDX);
    w_advance    = (r_state == ST_SHIFT) && shift_en;
    w_accept     = load_valid && !r_hold_valid && !abort;
    w_take       = 1'b0;
    w_shifted    = LSB_FIRST ? {1'b0, r_shift[DATA_W-1:1]} : {r_shift[DATA_W-2:0], 1'b0};
    case (r_state)
      ST_IDLE: begin
        if (r_hold_valid) begin
          w_state_next = ST_SHIFT;
          w_take       = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (shift_en && w_last) begin
          if (r_hold_valid) begin
            w_take = 1'b1;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (abort) begin
      w_state_next = ST_IDLE;
      w_take       = 1'b0;
    end
  end

  // Datapath: holding buffer, shift register, bit counter and the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift      <= '0;
      r_hold_data  <= '0;
      r_hold_valid <= 1'b0;
      r_cnt        <= '0;
      r_done       <= 1'b0;
    end else if (abort) begin
      r_hold_valid <= 1'b0;
      r_cnt        <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= w_advance && w_last;
      if (w_accept) begin
        r_hold_data  <= data_in;
        r_hold_valid <= 1'b1;
      end else if (w_take) begin
        r_hold_valid <= 1'b0;
      end
      if (w_take) begin
        r_shift <= r_hold_data;
        r_cnt   <= '0;
      end else if (w_advance) begin
        if (w_last) begin
          r_cnt <= '0;
        end else begin
          r_shift <= w_shifted;
          r_cnt   <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign load_ready = !r_hold_valid;
  assign busy       = (r_state == ST_SHIFT);
  assign done       = r_done;
  assign bit_idx    = r_cnt;
  assign mosi       = (r_state == ST_SHIFT) ? (LSB_FIRST ? r_shift[0] : r_shift[DATA_W-1])
                                            : IDLE_LEVEL;

endmodule

// File: doc/spi_piso_shifter.md
Name: spi_piso_shifter

Overview:
Parametrised serialiser for the SPI master transmit path; successor to the fixed 8-bit MOSI shifter. Adds configurable word width and bit order, a one-entry holding buffer with a valid/ready load handshake, per-bit advance strobe, busy/done status and abort. Back-to-back words stream on MOSI with no gap bit. It sits between the byte/word source and the SCLK edge generator, which drives shift_en.

Parameters:
DATA_W, 8, word width in bits; legal range 2..32.
LSB_FIRST, 0, 0 = MSB transmitted first, 1 = LSB transmitted first.
IDLE_LEVEL, 0, mosi level while no word is shifting.

Ports:
clk  input  1  system clock; all state is updated on the rising edge.
rst_n  input  1  asynchronous active-low reset.
data_in  input  DATA_W  parallel word to transmit.
load_valid  input  1  data_in is valid.
load_ready  output  1  holding buffer empty; the word is accepted when load_valid and load_ready are both high.
shift_en  input  1  one-cycle strobe; advances one bit (the launch edge of SCLK).
abort  input  1  synchronous flush of the shifter and the holding buffer.
mosi  output  1  serial data out.
busy  output  1  a word is shifting.
done  output  1  one-cycle pulse after the last bit of a word is consumed.
bit_idx  output  $clog2(DATA_W)  index of the bit currently on mosi (0 = first bit sent).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, shift reg=0, hold_valid=0, bit counter=0, done=0. Outputs: mosi=IDLE_LEVEL, busy=0, load_ready=1, bit_idx=0.
- Holding buffer: load_ready = !hold_valid (combinational from the register). On accept, hold_data<=data_in and hold_valid<=1. A load_valid while load_ready=0 is ignored; the source must hold the word.
- States: IDLE and SHIFT. busy = (state==SHIFT).
- IDLE: mosi=IDLE_LEVEL; shift_en is ignored. If hold_valid=1: shift reg<=hold_data, counter<=0, hold_valid<=0, state<=SHIFT.
- IDLE latency: word accepted on edge T -> hold_valid=1 after T -> transfer on edge T+1 -> busy=1 and first bit on mosi after edge T+1.
- SHIFT: mosi = shift reg[DATA_W-1] when LSB_FIRST=0, shift reg[0] when LSB_FIRST=1. mosi is driven by registers only (no combinational path from inputs). bit_idx = counter.
- SHIFT with shift_en=1 and counter<DATA_W-1: shift toward the output end, fill with 0, counter+1.
- SHIFT with shift_en=1 and counter==DATA_W-1 (last bit): done<=1 for exactly one cycle.
  - If hold_valid=1: reload from hold on the same edge, counter<=0, hold_valid<=0, stay in SHIFT. There is no idle bit between words.
  - Otherwise: state<=IDLE.
- SHIFT with shift_en=0: all state holds.
- Load accept and hold-to-shifter transfer never coincide, because accept requires hold_valid=0.
- abort=1 (priority over everything except reset): state<=IDLE, hold_valid<=0, counter<=0, done<=0. A load presented in the same cycle is dropped; load_ready is 1 the next cycle. A partial word is discarded and no done pulse is generated.
- Reset mid-word: immediate return to reset values; no done pulse.
- Counter width is $clog2(DATA_W). It wraps only through reload to 0 and never increments past DATA_W-1.

Test Plan:
1. DATA_W=8, LSB_FIRST=0, load 0xA5, shift_en every cycle -> mosi sequence 1,0,1,0,0,1,0,1. busy high for 8 cycles. done pulses once, on the cycle after the 8th shift. mosi returns to 0.
2. LSB_FIRST=1, load 0xA5 -> mosi sequence 1,0,1,0,0,1,0,1 in bit order b0..b7. bit_idx steps 0..7.
3. Back-to-back streaming: load 0x3C, then 0xC3 while the first word shifts, shift_en every cycle -> 16 contiguous bits 00111100 11000011. busy never drops between words. done pulses twice, 8 cycles apart. load_ready is low from the 0xC3 accept until the reload.
4. shift_en every 4th cycle, word 0x81 -> each mosi bit is stable for 4 cycles. Total busy time is 32 cycles.
5. Abort: abort after 3 shifts of 0xFF, with 0x55 in hold -> idle level on mosi the next cycle. busy=0, load_ready=1, no done pulse. The next load of 0x0F transmits cleanly.
6. Reset mid-word: rst_n low mid-word, asserted between clock edges -> outputs go to reset values at once without a clock edge. Hold is cleared.
7. Full holding buffer: load_valid while hold is full -> word ignored, load_ready stays 0.
8. DATA_W=16 build, word 0xBEEF -> 16 bits MSB-first, done after the 16th shift.
